piso_serial_tx: RTL and testbench
=================================

# piso_serial_tx

Parallel-in, serial-out frame transmitter for the shift-register family. It accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out on a single line as a framed serial stream: start bit, data bits, optional even-parity bit, stop bit. It is the sending end of a parallel-to-serial link and feeds a serial-in receiver on the far side.

## Interface
- WIDTH, 4: data bits per frame; must be ≥ 1.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; must be ≥ 1.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
- MSB_FIRST, 1: 1 sends pi[WIDTH-1] first; 0 sends pi[0] first.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- pi  input  WIDTH  parallel data word, sampled only on handshake.
- load_valid  input  1  a word is offered on pi.
- load_ready  output  1  transmitter is idle and accepts a word this cycle.
- so  output  1  serial output; idle level 1.
- frame  output  1  high while start, data, parity or stop bit is driven.
- done  output  1  one-cycle pulse after the stop bit of a completed frame.

## Operation
- All outputs are registered. Reset values: so=1, frame=0, done=0, load_ready=0. The shift register, bit-period counter and bit counter clear to 0.
- Reset dominates every other input at the same edge. A load_valid seen while reset=0 is ignored.
- A word is accepted at a rising edge where load_valid=1, load_ready=1 and reset=1. At that edge pi is copied into the internal shift register and parity is computed as the XOR of all data bits.
- pi is ignored at every other time.
- States and transitions:
  - IDLE: so=1, frame=0, load_ready=1. On accept, go to START.
  - START: so=0. After CLKS_PER_BIT cycles, go to DATA.
  - DATA: drives one data bit per CLKS_PER_BIT cycles in the order set by MSB_FIRST, WIDTH bits total. Then go to PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY: so=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: so=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly one cycle.
- frame=1 in START, DATA, PARITY and STOP.
- load_ready=0 in every state except IDLE.
- Frame length N = WIDTH + PARITY_EN + 2 bits, which is N·CLKS_PER_BIT cycles.
- Counter widths are clog2 of their terminal values, minimum 1 bit. Counters never wrap mid-frame; each one reloads at its bit or state boundary.
- Reset low mid-frame aborts the frame at that edge. No done pulse is produced, and the outputs take their reset values. After reset is released, the next frame starts from a clean state.
- After reset release, load_ready rises at the first edge with reset=1.

## Timing
- Accept at edge k. so=0 and frame=1 from cycle k+1 for CLKS_PER_BIT cycles.
- Data bit i (0 = first sent) is on so for cycles k+1+C·(1+i) through k+C·(2+i), where C = CLKS_PER_BIT.
- The stop bit occupies the last C cycles of the frame.
- Cycle k+1+N·C: so=1, frame=0, done=1, load_ready=1. If load_valid=1 in this cycle, the word is accepted at its closing edge, and the next start bit begins one cycle later.
- The minimum gap between frames is exactly one idle cycle at so=1.
- If load_valid is held high during a frame, nothing happens until load_ready returns to 1.

## Test plan
- Reset: reset=0 for 3 cycles while load_valid=1 with pi=4'hF. Required: so=1, frame=0, done=0, load_ready=0 throughout. load_ready=1 after the first edge with reset=1, and no frame starts from the ignored load.
- Basic frame, defaults (WIDTH=4, C=4, parity on, MSB first): accept pi=4'b1011. Required so sequence, each bit held 4 cycles: 0, 1, 0, 1, 1, parity 1, stop 1. That is 28 frame cycles, with done=1 in cycle 29 after the accept edge.
- Stability: after accepting 4'b1011, change pi to 4'b0000 at cycle 6 and hold load_valid=1. Required: the serial stream is unchanged, and the second word is accepted only in the done cycle.
- Back-to-back: load_valid held at 1 with 4'b0110, then 4'b1001. Required: parity bits are 0 and 0. Exactly one idle cycle at so=1 separates the stop bit and the next start bit. done pulses once per frame.
- Abort: reset=0 for one edge at cycle 10 of a frame. Required: so=1 and frame=0 at that edge, with no done pulse. load_ready=1 one edge after release, and a following 4'b0101 frame is transmitted correctly.
- Variant (PARITY_EN=0, MSB_FIRST=0, C=1): accept 4'b0001. Required so sequence: 0, 1, 0, 0, 0, 1 over 6 cycles, with done in cycle 7.

Source files
------------

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in, serial-out frame transmitter.
// Frames a WIDTH-bit word as start, data, optional even parity, and stop bits.
// Each bit is held for CLKS_PER_BIT cycles. All outputs are registered.
module piso_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             frame,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic [WIDTH-1:0] sh, sh_nxt, sh_shift;
  logic             par, par_nxt;
  logic             so_nxt, frame_nxt, done_nxt, ready_nxt;
  logic             bit_end;

  // Bit that goes on the line next from a given shift-register image.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // State, counters, shift register and registered outputs; reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      sh         <= '0;
      par        <= 1'b0;
      so         <= 1'b1;
      frame      <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bitcnt     <= bitcnt_nxt;
      sh         <= sh_nxt;
      par        <= par_nxt;
      so         <= so_nxt;
      frame      <= frame_nxt;
      done       <= done_nxt;
      load_ready <= ready_nxt;
    end
  end

  // Next state plus the output values that state will present next cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitcnt_nxt = bitcnt;
    sh_nxt     = sh;
    par_nxt    = par;
    so_nxt     = so;
    frame_nxt  = frame;
    done_nxt   = 1'b0;
    ready_nxt  = load_ready;
    sh_shift   = (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);
    bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));

    case (state)
      IDLE: begin
        so_nxt    = 1'b1;
        frame_nxt = 1'b0;
        ready_nxt = 1'b1;
        if (load_valid && load_ready) begin
          state_nxt  = START;
          sh_nxt     = pi;
          par_nxt    = ^pi;
          cnt_nxt    = '0;
          bitcnt_nxt = '0;
          so_nxt     = 1'b0;
          frame_nxt  = 1'b1;
          ready_nxt  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt  = DATA;
          cnt_nxt    = '0;
          bitcnt_nxt = '0;
          so_nxt     = head_bit(sh);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bitcnt == BW'(WIDTH - 1)) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              so_nxt    = par;
            end else begin
              state_nxt = STOP;
              so_nxt    = 1'b1;
            end
          end else begin
            sh_nxt     = sh_shift;
            bitcnt_nxt = bitcnt + BW'(1);
            so_nxt     = head_bit(sh_shift);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
          so_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          so_nxt    = 1'b1;
          frame_nxt = 1'b0;
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        so_nxt    = 1'b1;
        frame_nxt = 1'b0;
        ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed testbench for piso_serial_tx: default build plus an LSB-first,
// no-parity, one-clock-per-bit build driven from the same clock and reset.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pi;
  logic       load_valid;
  logic       load_ready, so, frame, done;

  logic [3:0] pi_v;
  logic       lv_v;
  logic       lr_v, so_v, fr_v, dn_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_serial_tx #(
    .WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .MSB_FIRST(1)
  ) u_dut (
    .clk(clk), .reset(reset), .pi(pi), .load_valid(load_valid),
    .load_ready(load_ready), .so(so), .frame(frame), .done(done)
  );

  piso_serial_tx #(
    .WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0), .MSB_FIRST(0)
  ) u_var (
    .clk(clk), .reset(reset), .pi(pi_v), .load_valid(lv_v),
    .load_ready(lr_v), .so(so_v), .frame(fr_v), .done(dn_v)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word, then check every cycle of its frame and the done cycle.
  // exp[6] is the start bit, exp[0] the stop bit.
  task automatic send_frame(input string tag, input logic [3:0] word,
                            input logic [6:0] exp, input bit drop_valid,
                            input bit swap_pi);
    int w = 0;
    pi = word;
    load_valid = 1'b1;
    while (load_ready !== 1'b1 && w < 200) begin
      step();
      w++;
    end
    if (w >= 200) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    step();
    if (drop_valid) load_valid = 1'b0;
    for (int j = 1; j <= 28; j++) begin
      chk({tag, "_so"}, {31'd0, so}, {31'd0, exp[6 - (j - 1) / 4]});
      chk({tag, "_frame"}, {31'd0, frame}, 32'd1);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
      if (swap_pi && j == 6) pi = 4'b0000;
      step();
    end
    chk({tag, "_end_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_end_so"}, {31'd0, so}, 32'd1);
    chk({tag, "_end_frame"}, {31'd0, frame}, 32'd0);
    chk({tag, "_end_ready"}, {31'd0, load_ready}, 32'd1);
  endtask

  initial begin
    logic [5:0] expv;
    int w;

    // Reset held with a load offered: must be ignored.
    reset = 1'b0;
    load_valid = 1'b1;
    pi = 4'hF;
    lv_v = 1'b0;
    pi_v = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_so", {31'd0, so}, 32'd1);
      chk("rst_frame", {31'd0, frame}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_var_ready", {31'd0, lr_v}, 32'd0);
    end
    reset = 1'b1;
    load_valid = 1'b0;
    step();
    chk("rel_ready", {31'd0, load_ready}, 32'd1);
    chk("rel_frame", {31'd0, frame}, 32'd0);
    step();
    chk("rel_noframe", {31'd0, frame}, 32'd0);
    chk("rel_so", {31'd0, so}, 32'd1);

    // Basic frame 1011 with pi changed mid-frame and load_valid held.
    send_frame("basic", 4'b1011, 7'b0101111, 1'b0, 1'b1);
    // The word 0000 set mid-frame is taken at the done-cycle edge.
    send_frame("stab2", 4'b0000, 7'b0000001, 1'b0, 1'b0);

    // Back-to-back frames, both with even parity 0.
    send_frame("b2b_a", 4'b0110, 7'b0011001, 1'b0, 1'b0);
    send_frame("b2b_b", 4'b1001, 7'b0100101, 1'b1, 1'b0);
    step();
    chk("idle_frame", {31'd0, frame}, 32'd0);
    chk("idle_so", {31'd0, so}, 32'd1);
    chk("idle_done", {31'd0, done}, 32'd0);

    // Abort mid-frame with a single reset edge at cycle 10.
    pi = 4'b0101;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("abort_started", {31'd0, frame}, 32'd1);
    repeat (9) step();
    reset = 1'b0;
    step();
    chk("abort_so", {31'd0, so}, 32'd1);
    chk("abort_frame", {31'd0, frame}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, load_ready}, 32'd0);
    reset = 1'b1;
    step();
    chk("abort_rel_ready", {31'd0, load_ready}, 32'd1);
    chk("abort_rel_done", {31'd0, done}, 32'd0);
    chk("abort_rel_frame", {31'd0, frame}, 32'd0);
    send_frame("after_abort", 4'b0101, 7'b0010101, 1'b1, 1'b0);

    // Variant build: LSB first, no parity, one clock per bit.
    expv = 6'b010001;
    pi_v = 4'b0001;
    lv_v = 1'b1;
    w = 0;
    while (lr_v !== 1'b1 && w < 200) begin
      step();
      w++;
    end
    if (w >= 200) chk("var_timeout", 32'd0, 32'd1);
    step();
    lv_v = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("var_so", {31'd0, so_v}, {31'd0, expv[5 - j]});
      chk("var_frame", {31'd0, fr_v}, 32'd1);
      chk("var_done", {31'd0, dn_v}, 32'd0);
      step();
    end
    chk("var_end_done", {31'd0, dn_v}, 32'd1);
    chk("var_end_so", {31'd0, so_v}, 32'd1);
    chk("var_end_frame", {31'd0, fr_v}, 32'd0);
    step();
    chk("var_done_once", {31'd0, dn_v}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
